// File: rtl/reg_file_wb_pkg.sv
// Shared register-file constants (register count, address/data widths, scoreboard depth)
// and the counter type used by the in-flight write scoreboard.
package reg_file_wb_pkg;

    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_CNT_W    = 2;

    typedef logic [RF_CNT_W-1:0] sb_cnt_t;

    // Largest value a scoreboard counter can hold before issue must stall.
    function automatic sb_cnt_t sb_cnt_max();
        return '1;
    endfunction

endpackage

// File: rtl/reg_file_wb_scoreboard.sv
// Per-register in-flight write counters; flags RAW hazards on the read ports and stalls issue
// when the destination counter is saturated.
module rf_scoreboard
    import reg_file_wb_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_valid,
    input  logic [ADDR_W-1:0] inc_addr,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              issue_stall
);

    sb_cnt_t cnt [NUM_REGS];
    logic    inc_en;

    // A write landing this cycle that retires the last pending write is covered by the bypass.
    function automatic logic busy_of(input logic [ADDR_W-1:0] a);
        logic last_landing;
        last_landing = dec_valid && (dec_addr == a) && (cnt[a] == sb_cnt_t'(1));
        return (cnt[a] != '0) && !last_landing;
    endfunction

    always_comb begin
        issue_stall = inc_valid && (inc_addr != '0) && (cnt[inc_addr] == sb_cnt_max())
                      && !(dec_valid && (dec_addr == inc_addr));
        inc_en      = inc_valid && (inc_addr != '0) && !issue_stall;
        rs1_busy    = busy_of(rs1_addr);
        rs2_busy    = busy_of(rs2_addr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_en && (inc_addr == ADDR_W'(r)) && !(dec_valid && (dec_addr == ADDR_W'(r))))
                    cnt[r] <= cnt[r] + sb_cnt_t'(1);
                else if (dec_valid && (dec_addr == ADDR_W'(r)) && !(inc_en && (inc_addr == ADDR_W'(r)))
                         && (cnt[r] != '0))
                    cnt[r] <= cnt[r] - sb_cnt_t'(1);
            end
        end
    end

    // Writeback to a register with nothing in flight: saturates at 0, only observed in simulation.
    cover property (@(posedge clk) disable iff (reset)
        dec_valid && (dec_addr != '0) && (cnt[dec_addr] == '0));

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file: WriteBack write port, two registered decode read ports with
// same-cycle write bypass, and an in-flight write scoreboard for hazard/stall detection.
module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] WrtBck_Addr,
    input  logic [DATA_W-1:0] WrtBck_Data,
    input  logic              Wr_En,
    input  logic [ADDR_W-1:0] Rs1_Addr,
    input  logic [ADDR_W-1:0] Rs2_Addr,
    input  logic              Issue_Valid,
    input  logic [ADDR_W-1:0] Issue_Rd,
    output logic [DATA_W-1:0] Rs1_Data,
    output logic [DATA_W-1:0] Rs2_Data,
    output logic              Rs1_Busy,
    output logic              Rs2_Busy,
    output logic              Issue_Stall
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rs1_data_p1;
    logic [DATA_W-1:0] rs2_data_p1;

    // x0 reads zero; a same-cycle write to the read address wins over the stored value.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        if (a == '0)
            return '0;
        else if (Wr_En && (WrtBck_Addr == a))
            return WrtBck_Data;
        else
            return regs[a];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (Wr_En && (WrtBck_Addr != '0)) begin
            regs[WrtBck_Addr] <= WrtBck_Data;
        end
    end

    // ---- stage p1: registered read ports ----
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
        end else begin
            rs1_data_p1 <= read_port(Rs1_Addr);
            rs2_data_p1 <= read_port(Rs2_Addr);
        end
    end

    assign Rs1_Data = rs1_data_p1;
    assign Rs2_Data = rs2_data_p1;

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .inc_valid   (Issue_Valid),
        .inc_addr    (Issue_Rd),
        .dec_valid   (Wr_En),
        .dec_addr    (WrtBck_Addr),
        .rs1_addr    (Rs1_Addr),
        .rs2_addr    (Rs2_Addr),
        .rs1_busy    (Rs1_Busy),
        .rs2_busy    (Rs2_Busy),
        .issue_stall (Issue_Stall)
    );

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb: reset, write/read, bypass, hazard,
// saturation stall and multiple in-flight writes.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  WrtBck_Addr;
    logic [31:0] WrtBck_Data;
    logic        Wr_En;
    logic [4:0]  Rs1_Addr;
    logic [4:0]  Rs2_Addr;
    logic        Issue_Valid;
    logic [4:0]  Issue_Rd;
    logic [31:0] Rs1_Data;
    logic [31:0] Rs2_Data;
    logic        Rs1_Busy;
    logic        Rs2_Busy;
    logic        Issue_Stall;

    int checks = 0;
    int errors = 0;

    reg_file_wb dut (
        .clk         (clk),
        .reset       (reset),
        .WrtBck_Addr (WrtBck_Addr),
        .WrtBck_Data (WrtBck_Data),
        .Wr_En       (Wr_En),
        .Rs1_Addr    (Rs1_Addr),
        .Rs2_Addr    (Rs2_Addr),
        .Issue_Valid (Issue_Valid),
        .Issue_Rd    (Issue_Rd),
        .Rs1_Data    (Rs1_Data),
        .Rs2_Data    (Rs2_Data),
        .Rs1_Busy    (Rs1_Busy),
        .Rs2_Busy    (Rs2_Busy),
        .Issue_Stall (Issue_Stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        reset       = 1'b1;
        WrtBck_Addr = '0;
        WrtBck_Data = '0;
        Wr_En       = 1'b0;
        Rs1_Addr    = '0;
        Rs2_Addr    = '0;
        Issue_Valid = 1'b0;
        Issue_Rd    = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_rs1_data", Rs1_Data, 32'h0);
        check("reset_rs2_data", Rs2_Data, 32'h0);
        check("reset_stall", {31'b0, Issue_Stall}, 32'h0);

        // 1: reset wipes a written register
        Wr_En = 1'b1; WrtBck_Addr = 5'd3; WrtBck_Data = 32'hDEADBEEF;
        tick();
        Wr_En = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        Rs1_Addr = 5'd3;
        #1;
        check("t1_rs1_busy", {31'b0, Rs1_Busy}, 32'h0);
        check("t1_rs2_busy", {31'b0, Rs2_Busy}, 32'h0);
        tick();
        check("t1_x3_after_reset", Rs1_Data, 32'h0);

        // 2: write then read; write to x0 is dropped
        Wr_En = 1'b1; WrtBck_Addr = 5'd5; WrtBck_Data = 32'h12345678;
        Rs1_Addr = 5'd0;
        tick();
        Wr_En = 1'b0;
        Rs1_Addr = 5'd5;
        tick();
        check("t2_read_x5", Rs1_Data, 32'h12345678);
        Wr_En = 1'b1; WrtBck_Addr = 5'd0; WrtBck_Data = 32'hFFFFFFFF;
        Rs2_Addr = 5'd0;
        tick();
        Wr_En = 1'b0;
        check("t2_x0_bypass", Rs2_Data, 32'h0);
        tick();
        check("t2_x0_stored", Rs2_Data, 32'h0);

        // 3: same-cycle write bypass on both ports
        Wr_En = 1'b1; WrtBck_Addr = 5'd7; WrtBck_Data = 32'hA5A5A5A5;
        Rs1_Addr = 5'd7; Rs2_Addr = 5'd7;
        tick();
        Wr_En = 1'b0;
        check("t3_rs1_bypass", Rs1_Data, 32'hA5A5A5A5);
        check("t3_rs2_bypass", Rs2_Data, 32'hA5A5A5A5);

        // 4: single in-flight write; landing write clears busy combinationally
        Rs1_Addr = 5'd0; Rs2_Addr = 5'd0;
        Issue_Valid = 1'b1; Issue_Rd = 5'd9;
        #1;
        check("t4_issue_no_stall", {31'b0, Issue_Stall}, 32'h0);
        tick();
        Issue_Valid = 1'b0;
        Rs1_Addr = 5'd9;
        #1;
        check("t4_busy_pending", {31'b0, Rs1_Busy}, 32'h1);
        Wr_En = 1'b1; WrtBck_Addr = 5'd9; WrtBck_Data = 32'h00000099;
        #1;
        check("t4_busy_landing", {31'b0, Rs1_Busy}, 32'h0);
        tick();
        Wr_En = 1'b0;
        #1;
        check("t4_data_bypass", Rs1_Data, 32'h00000099);
        check("t4_busy_after", {31'b0, Rs1_Busy}, 32'h0);

        // 5: saturation on x4
        Rs1_Addr = 5'd0; Rs2_Addr = 5'd4;
        Issue_Valid = 1'b1; Issue_Rd = 5'd4;
        tick();
        tick();
        check("t5_no_stall_cnt2", {31'b0, Issue_Stall}, 32'h0);
        tick();
        check("t5_stall_cnt3", {31'b0, Issue_Stall}, 32'h1);
        check("t5_busy_cnt3", {31'b0, Rs2_Busy}, 32'h1);
        tick();
        check("t5_still_stalled", {31'b0, Issue_Stall}, 32'h1);
        Wr_En = 1'b1; WrtBck_Addr = 5'd4; WrtBck_Data = 32'h00000044;
        #1;
        check("t5_stall_released", {31'b0, Issue_Stall}, 32'h0);
        tick();
        Wr_En = 1'b0;
        #1;
        check("t5_inc_dec_holds", {31'b0, Issue_Stall}, 32'h1);
        Issue_Valid = 1'b0;
        #1;
        check("t5_no_valid_no_stall", {31'b0, Issue_Stall}, 32'h0);
        Wr_En = 1'b1;
        tick();
        check("t5_drain_cnt2", {31'b0, Rs2_Busy}, 32'h1);
        tick();
        check("t5_drain_cnt1_landing", {31'b0, Rs2_Busy}, 32'h0);
        tick();
        Wr_En = 1'b0;
        #1;
        check("t5_drained", {31'b0, Rs2_Busy}, 32'h0);

        // 6: two in-flight writes to x6, then reset with cnt[6]=2
        Rs2_Addr = 5'd6;
        Issue_Valid = 1'b1; Issue_Rd = 5'd6;
        tick();
        tick();
        Issue_Valid = 1'b0;
        Wr_En = 1'b1; WrtBck_Addr = 5'd6; WrtBck_Data = 32'h00000066;
        #1;
        check("t6_busy_first_wb", {31'b0, Rs2_Busy}, 32'h1);
        tick();
        Wr_En = 1'b0;
        #1;
        check("t6_busy_cnt1", {31'b0, Rs2_Busy}, 32'h1);
        Wr_En = 1'b1;
        #1;
        check("t6_busy_second_wb", {31'b0, Rs2_Busy}, 32'h0);
        tick();
        Wr_En = 1'b0;
        #1;
        check("t6_busy_cleared", {31'b0, Rs2_Busy}, 32'h0);
        check("t6_rs2_data", Rs2_Data, 32'h00000066);
        Issue_Valid = 1'b1;
        tick();
        tick();
        Issue_Valid = 1'b0;
        #1;
        check("t6_busy_before_reset", {31'b0, Rs2_Busy}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t6_busy_after_reset", {31'b0, Rs2_Busy}, 32'h0);
        check("t6_data_after_reset", Rs2_Data, 32'h0);
        Issue_Valid = 1'b1;
        tick();
        tick();
        #1;
        check("t6_cnt_restarted", {31'b0, Issue_Stall}, 32'h0);
        Issue_Valid = 1'b0;
        Issue_Rd = 5'd0;
        Rs1_Addr = 5'd0;
        #1;
        check("x0_never_busy", {31'b0, Rs1_Busy}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: observed no completion, expected finish before 20000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
